vcache_dma_arbiter: RTL
=======================

VCACHE_DMA_ARBITER -- requirements
Module: vcache_dma_arbiter

Interface
REQ-001 SHALL have parameter num_caches_p, default 4: number of vcaches sharing one DMA channel.
REQ-002 SHALL have parameter addr_width_p, default 32: DMA packet address width.
REQ-003 SHALL have parameter data_width_p, default 32: DMA data beat width.
REQ-004 SHALL have parameter block_size_in_words_p, default 8: beats per DMA block, read or write.
REQ-005 SHALL have parameter max_reads_p, default 4: outstanding read requests tracked.
REQ-006 SHALL use one clock and an asynchronous, active-low reset.
REQ-007 SHALL have port clk_i, input, 1: the only clock.
REQ-008 SHALL have port reset_n_i, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have port dma_pkt_i, input, N x pkt width: per-cache DMA packet (write_not_read, addr).
REQ-010 SHALL have ports dma_pkt_v_i, input, N, and dma_pkt_yumi_o, output, N: per-cache packet handshake.
REQ-011 SHALL have ports dma_data_i, input, N x data_width_p, plus dma_data_v_i, input, N, and dma_data_yumi_o, output, N: per-cache write data.
REQ-012 SHALL have ports dma_data_o, output, data_width_p, plus dma_data_v_o, output, N, and dma_data_ready_i, input, N: read data returned to caches.
REQ-013 SHALL have ports mem_pkt_o, output, pkt width, plus mem_pkt_v_o, output, 1, and mem_pkt_yumi_i, input, 1: packet to memory.
REQ-014 SHALL have ports mem_wdata_o, output, data_width_p, plus mem_wdata_v_o, output, 1, and mem_wdata_yumi_i, input, 1: write data to memory.
REQ-015 SHALL have ports mem_rdata_i, input, data_width_p, plus mem_rdata_v_i, input, 1, and mem_rdata_ready_o, output, 1: read data from memory.

Function
REQ-016 SHALL run a packet FSM with states IDLE and WDATA.
REQ-017 In IDLE, SHALL pick one cache among eligible dma_pkt_v_i round-robin, starting at rr_ptr, and drive its packet on mem_pkt_o with mem_pkt_v_o=1.
- Eligible: dma_pkt_v_i set, and for reads the ID FIFO is not full.
REQ-018 In IDLE, mem_pkt_v_o SHALL be 0 when no cache is eligible.
REQ-019 On mem_pkt_yumi_i, SHALL assert dma_pkt_yumi_o only for the granted cache, in the same cycle.
- rr_ptr becomes grant+1 modulo num_caches_p.
REQ-020 On an accepted read packet, SHALL push the grant ID into the ID FIFO and stay in IDLE.
REQ-021 On an accepted write packet, SHALL latch the grant as wr_id, clear wbeat_cnt and go to WDATA.
REQ-022 In WDATA, mem_pkt_v_o SHALL be 0.
- mem_wdata_o/v_o mirror dma_data_i/v_i[wr_id]; dma_data_yumi_o[wr_id] = mem_wdata_yumi_i; all other yumi bits are 0.
REQ-023 Each write beat handshake SHALL increment wbeat_cnt.
- The handshake with wbeat_cnt = block_size_in_words_p-1 returns the FSM to IDLE in the next cycle.
REQ-024 Read return SHALL run independently of the FSM.
- If the ID FIFO is non-empty: dma_data_o = mem_rdata_i; dma_data_v_o[head] = mem_rdata_v_i; mem_rdata_ready_o = dma_data_ready_i[head].
- If it is empty: mem_rdata_ready_o = 0 and all dma_data_v_o bits are 0.
REQ-025 Each read beat handshake SHALL increment rbeat_cnt.
- The last beat (block_size_in_words_p-1) pops the FIFO and clears rbeat_cnt.
REQ-026 A read packet push SHALL be blocked when the FIFO is full, even if a pop occurs in the same cycle.
- A push and a pop in one cycle with the FIFO not full SHALL both take effect, with count unchanged.
REQ-027 Counters SHALL be $clog2(block_size_in_words_p) bits wide and wrap only through the explicit clear.
REQ-028 Write data SHALL flow only in WDATA, so beats never interleave between caches.
- Read data SHALL be routed strictly in packet-acceptance order.

Reset
REQ-029 While reset_n_i is 0, the following SHALL hold: state=IDLE, rr_ptr=0, wr_id=0, both counters 0, FIFO empty.
- All v/yumi/ready outputs are 0.
REQ-030 Reset asserted mid-block SHALL abandon in-flight write and read beats without any further handshakes.

Structure
REQ-031 A shared package SHALL hold the FSM state enum and the DMA packet struct declaration.
REQ-032 The ID FIFO SHALL be one sub-module, vcache_dma_id_fifo.
- Depth max_reads_p, width $clog2(num_caches_p), with the same clock and reset.

Verification
REQ-033 Caches 0 and 2 request reads in the same cycle with rr_ptr=0 -> cache 0 is granted first, then cache 2; 16 read beats return to cache 0 then cache 2.
REQ-034 Cache 1 writes with block size 8 while cache 3 holds a read valid -> 8 beats come from cache 1 only, and cache 3 is granted in the cycle after the FSM returns to IDLE.
REQ-035 Four reads are outstanding (FIFO full) and a fifth read is pending -> mem_pkt_v_o=0 until the first block pops, then the fifth read is granted.
REQ-036 dma_data_ready_i[head]=0 for 3 cycles with mem_rdata_v_i=1 -> mem_rdata_ready_o=0 and rbeat_cnt holds.
REQ-037 reset_n_i is pulsed low at write beat 4 -> all outputs are 0 immediately, state=IDLE, and the next request is granted from rr_ptr=0.

Source files
------------

// File: rtl/vcache_dma_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vcache_dma_arbiter_pkg
//   Shared types for the vcache DMA arbiter slice.
//   - arb_state_e      : packet FSM states (IDLE accepts packets, WDATA streams
//                        one write block from the owning cache)
//   - vcache_dma_pkt_s : DMA packet layout {write_not_read, addr}; the arbiter
//                        ports carry the same bit layout as flat vectors so the
//                        address width can be overridden per instance
//   - safe_clog2       : $clog2 clamped to at least 1 bit
// -----------------------------------------------------------------------------
package vcache_dma_arbiter_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WDATA = 1'b1
   } arb_state_e;

   localparam int unsigned dma_addr_width_gp = 32;

   typedef struct packed {
      logic                         write_not_read;
      logic [dma_addr_width_gp-1:0] addr;
   } vcache_dma_pkt_s;

   function automatic int unsigned safe_clog2(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vcache_dma_id_fifo.sv
// -----------------------------------------------------------------------------
// vcache_dma_id_fifo
//   Small FIFO of cache IDs, one entry per outstanding read packet. The head
//   entry names the cache that owns the read data currently returning.
//   Ports:
//     clk_i, reset_n_i : clock, asynchronous active-low reset (empties FIFO)
//     data_i, v_i      : ID to push; push happens only when ready_o is high
//     ready_o          : not full (a pop in the same cycle does not free a slot)
//     data_o, v_o      : head ID and not-empty flag
//     yumi_i           : pop the head entry
// -----------------------------------------------------------------------------
module vcache_dma_id_fifo
   import vcache_dma_arbiter_pkg::*;
#(
   parameter int unsigned width_p = 2,
   parameter int unsigned els_p   = 4
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic [width_p-1:0] data_i,
   input  logic               v_i,
   output logic               ready_o,
   output logic [width_p-1:0] data_o,
   output logic               v_o,
   input  logic               yumi_i
);

   localparam int unsigned ptr_width_lp = safe_clog2(els_p);
   localparam int unsigned cnt_width_lp = $clog2(els_p + 1);
   localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);
   localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(els_p);

   logic [els_p-1:0][width_p-1:0] mem_q, mem_d;
   logic [ptr_width_lp-1:0]       wptr_q, wptr_d;
   logic [ptr_width_lp-1:0]       rptr_q, rptr_d;
   logic [cnt_width_lp-1:0]       count_q, count_d;
   logic                          push, pop;

   assign ready_o = (count_q != full_cnt_lp);
   assign v_o     = (count_q != '0);
   assign data_o  = mem_q[rptr_q];
   assign push    = v_i & ready_o;
   assign pop     = yumi_i & v_o;

   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push) begin
         mem_d[wptr_q] = data_i;
         wptr_d = (wptr_q == last_ptr_lp) ? '0 : wptr_q + ptr_width_lp'(1);
      end
      if (pop) begin
         rptr_d = (rptr_q == last_ptr_lp) ? '0 : rptr_q + ptr_width_lp'(1);
      end
      if (push && !pop) begin
         count_d = count_q + cnt_width_lp'(1);
      end else if (pop && !push) begin
         count_d = count_q - cnt_width_lp'(1);
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         mem_q   <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/vcache_dma_arbiter.sv
// -----------------------------------------------------------------------------
// vcache_dma_arbiter
//   Shares one memory DMA channel among num_caches_p vcaches.
//   Packets are granted round-robin. A write packet locks the channel until its
//   block of write beats has been transferred; read packets queue their cache
//   ID in an ID FIFO and read data is routed back in acceptance order,
//   independently of the packet FSM.
//   Ports:
//     clk_i, reset_n_i                          : clock, async active-low reset
//     dma_pkt_i/_v_i/_yumi_o                    : per-cache packets {wnr, addr}
//     dma_data_i/_v_i/_yumi_o                   : per-cache write data
//     dma_data_o, dma_data_v_o, dma_data_ready_i: read data back to caches
//     mem_pkt_o/_v_o/_yumi_i                    : packet to memory
//     mem_wdata_o/_v_o/_yumi_i                  : write data to memory
//     mem_rdata_i/_v_i, mem_rdata_ready_o       : read data from memory
// -----------------------------------------------------------------------------
module vcache_dma_arbiter
   import vcache_dma_arbiter_pkg::*;
#(
   parameter int unsigned num_caches_p          = 4,
   parameter int unsigned addr_width_p          = 32,
   parameter int unsigned data_width_p          = 32,
   parameter int unsigned block_size_in_words_p = 8,
   parameter int unsigned max_reads_p           = 4
) (
   input  logic                                     clk_i,
   input  logic                                     reset_n_i,

   input  logic [num_caches_p-1:0][addr_width_p:0]  dma_pkt_i,
   input  logic [num_caches_p-1:0]                  dma_pkt_v_i,
   output logic [num_caches_p-1:0]                  dma_pkt_yumi_o,

   input  logic [num_caches_p-1:0][data_width_p-1:0] dma_data_i,
   input  logic [num_caches_p-1:0]                  dma_data_v_i,
   output logic [num_caches_p-1:0]                  dma_data_yumi_o,

   output logic [data_width_p-1:0]                  dma_data_o,
   output logic [num_caches_p-1:0]                  dma_data_v_o,
   input  logic [num_caches_p-1:0]                  dma_data_ready_i,

   output logic [addr_width_p:0]                    mem_pkt_o,
   output logic                                     mem_pkt_v_o,
   input  logic                                     mem_pkt_yumi_i,

   output logic [data_width_p-1:0]                  mem_wdata_o,
   output logic                                     mem_wdata_v_o,
   input  logic                                     mem_wdata_yumi_i,

   input  logic [data_width_p-1:0]                  mem_rdata_i,
   input  logic                                     mem_rdata_v_i,
   output logic                                     mem_rdata_ready_o
);

   localparam int unsigned id_width_lp  = safe_clog2(num_caches_p);
   localparam int unsigned cnt_width_lp = safe_clog2(block_size_in_words_p);
   localparam logic [id_width_lp-1:0]  last_id_lp   = id_width_lp'(num_caches_p - 1);
   localparam logic [cnt_width_lp-1:0] last_beat_lp = cnt_width_lp'(block_size_in_words_p - 1);
   // Packet MSB is write_not_read, matching vcache_dma_pkt_s.
   localparam int unsigned wnr_bit_lp   = addr_width_p;

   arb_state_e              state_q, state_d;
   logic [id_width_lp-1:0]  rr_ptr_q, rr_ptr_d;
   logic [id_width_lp-1:0]  wr_id_q, wr_id_d;
   logic [cnt_width_lp-1:0] wbeat_cnt_q, wbeat_cnt_d;
   logic [cnt_width_lp-1:0] rbeat_cnt_q, rbeat_cnt_d;

   logic [num_caches_p-1:0] eligible;
   logic                    grant_v;
   logic [id_width_lp-1:0]  grant_id;
   logic [id_width_lp-1:0]  scan_id;

   logic                    fifo_push;
   logic                    fifo_ready;
   logic [id_width_lp-1:0]  fifo_head;
   logic                    fifo_v;
   logic                    fifo_pop;

   // Round-robin pick. Reads are only eligible while the ID FIFO has room;
   // the FIFO's ready ignores a same-cycle pop, so a full FIFO always blocks.
   always_comb begin
      eligible = '0;
      for (int unsigned i = 0; i < num_caches_p; i++) begin
         eligible[i] = dma_pkt_v_i[i] & (dma_pkt_i[i][wnr_bit_lp] | fifo_ready);
      end
      grant_v  = 1'b0;
      grant_id = '0;
      scan_id  = rr_ptr_q;
      for (int unsigned k = 0; k < num_caches_p; k++) begin
         if (!grant_v && eligible[scan_id]) begin
            grant_v  = 1'b1;
            grant_id = scan_id;
         end
         scan_id = (scan_id == last_id_lp) ? '0 : scan_id + id_width_lp'(1);
      end
   end

   // Packet FSM and write-data path. Outputs are gated by reset_n_i so every
   // handshake drops the moment reset is asserted, not at the next edge.
   always_comb begin
      state_d         = state_q;
      rr_ptr_d        = rr_ptr_q;
      wr_id_d         = wr_id_q;
      wbeat_cnt_d     = wbeat_cnt_q;
      mem_pkt_o       = dma_pkt_i[grant_id];
      mem_pkt_v_o     = 1'b0;
      dma_pkt_yumi_o  = '0;
      mem_wdata_o     = dma_data_i[wr_id_q];
      mem_wdata_v_o   = 1'b0;
      dma_data_yumi_o = '0;
      fifo_push       = 1'b0;
      if (reset_n_i) begin
         unique case (state_q)
            ST_IDLE: begin
               mem_pkt_v_o = grant_v;
               if (grant_v && mem_pkt_yumi_i) begin
                  dma_pkt_yumi_o[grant_id] = 1'b1;
                  rr_ptr_d = (grant_id == last_id_lp) ? '0 : grant_id + id_width_lp'(1);
                  if (dma_pkt_i[grant_id][wnr_bit_lp]) begin
                     wr_id_d     = grant_id;
                     wbeat_cnt_d = '0;
                     state_d     = ST_WDATA;
                  end else begin
                     fifo_push = 1'b1;
                  end
               end
            end
            ST_WDATA: begin
               mem_wdata_v_o             = dma_data_v_i[wr_id_q];
               dma_data_yumi_o[wr_id_q]  = mem_wdata_yumi_i;
               if (mem_wdata_yumi_i) begin
                  if (wbeat_cnt_q == last_beat_lp) begin
                     wbeat_cnt_d = '0;
                     state_d     = ST_IDLE;
                  end else begin
                     wbeat_cnt_d = wbeat_cnt_q + cnt_width_lp'(1);
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Read return: the FIFO head owns the memory read stream.
   always_comb begin
      rbeat_cnt_d       = rbeat_cnt_q;
      fifo_pop          = 1'b0;
      dma_data_o        = mem_rdata_i;
      dma_data_v_o      = '0;
      mem_rdata_ready_o = 1'b0;
      if (reset_n_i && fifo_v) begin
         dma_data_v_o[fifo_head] = mem_rdata_v_i;
         mem_rdata_ready_o       = dma_data_ready_i[fifo_head];
         if (mem_rdata_v_i && dma_data_ready_i[fifo_head]) begin
            if (rbeat_cnt_q == last_beat_lp) begin
               rbeat_cnt_d = '0;
               fifo_pop    = 1'b1;
            end else begin
               rbeat_cnt_d = rbeat_cnt_q + cnt_width_lp'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         wr_id_q     <= '0;
         wbeat_cnt_q <= '0;
         rbeat_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         wr_id_q     <= wr_id_d;
         wbeat_cnt_q <= wbeat_cnt_d;
         rbeat_cnt_q <= rbeat_cnt_d;
      end
   end

   vcache_dma_id_fifo #(
      .width_p (id_width_lp),
      .els_p   (max_reads_p)
   ) id_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .data_i    (grant_id),
      .v_i       (fifo_push),
      .ready_o   (fifo_ready),
      .data_o    (fifo_head),
      .v_o       (fifo_v),
      .yumi_i    (fifo_pop)
   );

endmodule
